// File: rtl/adder_if.sv
// Operand/result bundle for the registered add/subtract unit.
interface adder_if #(
   parameter int unsigned WORD_WIDTH = 16
);
   logic                  in_valid;
   logic                  sub;
   logic [WORD_WIDTH-1:0] A;
   logic [WORD_WIDTH-1:0] B;
   logic [WORD_WIDTH-1:0] out;
   logic                  out_valid;
   logic                  overflow;

   // Producer of operands, consumer of results.
   modport master (
      output in_valid, sub, A, B,
      input  out, out_valid, overflow
   );

   // The arithmetic unit itself.
   modport slave (
      input  in_valid, sub, A, B,
      output out, out_valid, overflow
   );
endinterface

// File: rtl/adder.sv
// Registered signed add/subtract with overflow detection and optional saturation.
module adder #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter bit          SATURATE   = 1'b0
) (
   input logic    clk,
   input logic    rst,
   adder_if.slave bus
);
   localparam int unsigned SUM_W = WORD_WIDTH + 1;
   localparam int unsigned MSB   = WORD_WIDTH - 1;

   logic [WORD_WIDTH-1:0] w_b_op;
   logic [SUM_W-1:0]      w_sum;
   logic [WORD_WIDTH-1:0] w_wrapped;
   logic                  w_ovf;
   logic [WORD_WIDTH-1:0] w_sat_val;
   logic [WORD_WIDTH-1:0] w_result;

   logic [WORD_WIDTH-1:0] r_out;
   logic                  r_overflow;
   logic                  r_out_valid;

   // Two's-complement sum at one extra bit; subtraction as A + ~B + 1.
   always_comb begin
      w_b_op    = bus.sub ? ~bus.B : bus.B;
      w_sum     = {bus.A[MSB], bus.A} + {w_b_op[MSB], w_b_op} + SUM_W'(bus.sub);
      w_wrapped = w_sum[WORD_WIDTH-1:0];
   end

   // Signed overflow: operands effectively share a sign that the wrapped result lost.
   always_comb begin
      w_ovf = 1'b0;
      if (bus.sub) begin
         w_ovf = (bus.A[MSB] != bus.B[MSB]) && (w_wrapped[MSB] != bus.A[MSB]);
      end else begin
         w_ovf = (bus.A[MSB] == bus.B[MSB]) && (w_wrapped[MSB] != bus.A[MSB]);
      end
   end

   // Clamp toward the sign of A when saturating, otherwise pass the wrapped sum.
   always_comb begin
      w_sat_val = {bus.A[MSB], {(WORD_WIDTH-1){~bus.A[MSB]}}};
      w_result  = w_wrapped;
      if (SATURATE && w_ovf) begin
         w_result = w_sat_val;
      end
   end

   // Output registers: reset clears, valid loads, idle holds result and flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out       <= '0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_out      <= w_result;
            r_overflow <= w_ovf;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.overflow  = r_overflow;
   assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_adder.sv
// Directed bench driving a wrapping and a saturating adder with identical vectors.
module tb_adder;
   localparam int unsigned W = 16;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   adder_if #(.WORD_WIDTH(W)) if_wrap ();
   adder_if #(.WORD_WIDTH(W)) if_sat ();

   adder #(.WORD_WIDTH(W), .SATURATE(1'b0)) u_wrap (
      .clk (clk),
      .rst (rst),
      .bus (if_wrap)
   );

   adder #(.WORD_WIDTH(W), .SATURATE(1'b1)) u_sat (
      .clk (clk),
      .rst (rst),
      .bus (if_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      if_wrap.in_valid = v;
      if_wrap.sub      = s;
      if_wrap.A        = a;
      if_wrap.B        = b;
      if_sat.in_valid  = v;
      if_sat.sub       = s;
      if_sat.A         = a;
      if_sat.B         = b;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then compare both instances (wrap value/flag, sat value/flag, valid).
   task automatic step(input string tag, input logic [W-1:0] ew, input logic ewo,
                       input logic [W-1:0] es, input logic eso, input logic ev);
      @(posedge clk);
      #1;
      check({tag, ".wrap_out"}, if_wrap.out, ew);
      check({tag, ".wrap_ovf"}, W'(if_wrap.overflow), W'(ewo));
      check({tag, ".sat_out"},  if_sat.out, es);
      check({tag, ".sat_ovf"},  W'(if_sat.overflow), W'(eso));
      check({tag, ".wrap_vld"}, W'(if_wrap.out_valid), W'(ev));
      check({tag, ".sat_vld"},  W'(if_sat.out_valid), W'(ev));
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset held two cycles with valid operands present.
      rst = 1'b1;
      drive(1'b1, 1'b0, 16'd5, 16'd7);
      step("rst0", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      step("rst1", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;
      step("first", 16'd12, 1'b0, 16'd12, 1'b0, 1'b1);

      // Back-to-back adds.
      drive(1'b1, 1'b0, 16'd156, 16'd12);
      step("add0", 16'd168, 1'b0, 16'd168, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'd148, 16'd45);
      step("add1", 16'd193, 1'b0, 16'd193, 1'b0, 1'b1);

      // Subtract and negative operands without overflow.
      drive(1'b1, 1'b1, 16'd12, 16'd156);
      step("sub0", 16'hFF70, 1'b0, 16'hFF70, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'hFF9C, 16'hFFE4);
      step("negadd", 16'hFF80, 1'b0, 16'hFF80, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
      step("m1m1", 16'hFFFE, 1'b0, 16'hFFFE, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 16'd5, 16'hFFFD);
      step("subneg", 16'd8, 1'b0, 16'd8, 1'b0, 1'b1);

      // Overflow boundaries.
      drive(1'b1, 1'b0, 16'h7FFF, 16'h0001);
      step("posovf", 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 16'h8000, 16'h0001);
      step("negovf_sub", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 16'h8000, 16'hFFFF);
      step("negovf_add", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 16'h0000, 16'h8000);
      step("sub_min", 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Idle after an overflow holds value and flag.
      drive(1'b0, 1'b0, 16'h1111, 16'h2222);
      step("hold_ovf", 16'h8000, 1'b1, 16'h7FFF, 1'b1, 1'b0);

      // Valid gating: one result, then three idle cycles with toggling operands.
      drive(1'b1, 1'b0, 16'd3, 16'd4);
      step("gate_v", 16'd7, 1'b0, 16'd7, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 16'hAAAA, 16'h5555);
      step("gate0", 16'd7, 1'b0, 16'd7, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 16'h5555, 16'hAAAA);
      step("gate1", 16'd7, 1'b0, 16'd7, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 16'h7FFF, 16'h7FFF);
      step("gate2", 16'd7, 1'b0, 16'd7, 1'b0, 1'b0);

      // Reset discards a result in flight and beats in_valid.
      drive(1'b1, 1'b0, 16'd1, 16'd1);
      step("pre_rst", 16'd2, 1'b0, 16'd2, 1'b0, 1'b1);
      rst = 1'b1;
      drive(1'b1, 1'b0, 16'h7FFF, 16'h7FFF);
      step("rst_mid", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b1, 1'b0, 16'd2, 16'd3);
      step("post_rst", 16'd5, 1'b0, 16'd5, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/adder.md
# adder

Registered signed two's-complement add/subtract unit, parameterised in word width. It is the shared arithmetic primitive of the CORDIC vectoring datapath, used for the X/Y/Z micro-rotation updates. It adds or subtracts two signed operands and flags signed overflow. It can either wrap or saturate the result, and delivers the result one clock after a valid input.

## Interface
Parameters:
- WORD_WIDTH, default 16: width in bits of A, B and out; must be at least 2.
- SATURATE, default 0: 0 means the result wraps modulo 2^WORD_WIDTH; 1 means the result clamps to the signed range on overflow.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
- in_valid  input  1  operands and sub are valid this cycle.
- sub  input  1  0 selects A + B; 1 selects A − B.
- A  input  WORD_WIDTH  signed operand.
- B  input  WORD_WIDTH  signed operand.
- out  output  WORD_WIDTH  signed registered result.
- out_valid  output  1  out and overflow hold a fresh result this cycle.
- overflow  output  1  the registered result overflowed the signed range.

## Operation
- Internal sum: A + (sub ? ~B : B) + sub, computed at WORD_WIDTH+1 bits, sign-extended.
- Signed overflow:
  - Add: A and B have the same sign and the wrapped result sign differs from it.
  - Sub: A and B have different signs and the wrapped result sign differs from A's.
- SATURATE=0: out is the low WORD_WIDTH bits of the sum; overflow is still reported.
- SATURATE=1 with overflow:
  - Positive overflow (A non-negative) gives out = 2^(WORD_WIDTH−1)−1, i.e. 0x7FFF at width 16.
  - Negative overflow gives out = −2^(WORD_WIDTH−1), i.e. 0x8000.
  - overflow flag = 1 in both cases.
- Without overflow, out equals the exact sum in both modes.
- Subtracting the most negative value (e.g. 0 − 0x8000) is an overflow and follows the rules above.
- The unit is purely arithmetic: no rounding, no shifting, no sign handling beyond two's complement.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N with in_valid=1 appear on out, overflow and out_valid=1 after edge N.
- One result per cycle, no backpressure; back-to-back valid inputs produce back-to-back valid outputs.
- in_valid=0 at an edge: out_valid goes to 0; out and overflow hold their previous values.
- rst=1 at an edge: out=0, overflow=0, out_valid=0, regardless of in_valid.
  - rst has priority over in_valid in the same cycle.
  - A result in flight is discarded.
- After rst is released, the first in_valid edge produces a result on the next cycle as normal.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=1, A=5, B=7 -> out=0, out_valid=0, overflow=0 throughout; first valid result appears the cycle after rst drops.
- Basic add, WORD_WIDTH=16: A=156, B=12, sub=0 -> out=168 one cycle later; then A=148, B=45 -> out=193. out_valid=1 and overflow=0 for both, delivered back-to-back.
- Subtract and negatives: A=12, B=156, sub=1 -> out=−144 (0xFF70); A=−100, B=−28, sub=0 -> out=−128; overflow=0 for both.
- Wrap overflow, SATURATE=0: A=0x7FFF, B=1, sub=0 -> out=0x8000, overflow=1. A=0x8000, B=1, sub=1 -> out=0x7FFF, overflow=1.
- Saturation, SATURATE=1: A=0x7FFF, B=1 -> out=0x7FFF, overflow=1. A=0x8000, B=0xFFFF (−1), sub=0 -> out=0x8000, overflow=1. A=0, B=0x8000, sub=1 -> out=0x7FFF, overflow=1.
- Valid gating: one valid input (A=3, B=4), then in_valid=0 for 3 cycles while A and B toggle -> out stays 7, out_valid pulses high for exactly one cycle.
